// File: rtl/sda_kernel_param_arbiter_pkg.sv
// Shared widths and the rotate-priority pick for the kernel parameter read-port arbiter.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package sda_param_arb_pkg;

    localparam int MaxReq = 16;

    // Width of a requester index; a single bit even for two requesters.
    function automatic int tagWidthOf(input int numReq);
        return (numReq <= 2) ? 1 : $clog2(numReq);
    endfunction

    // Occupancy counter width, able to hold the value depth itself.
    function automatic int countWidthOf(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // One-hot grant: first set bit of valid at or above ptr, wrapping modulo numReq.
    function automatic logic [MaxReq-1:0] rrGrant(input logic [MaxReq-1:0] valid,
                                                  input logic [3:0]        ptr,
                                                  input int                numReq);
        logic [MaxReq-1:0] g;
        logic              found;
        logic [3:0]        idx;
        g     = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < MaxReq; k++) begin
            if ((k < numReq) && !found) begin
                idx = 4'((int'(ptr) + k) % numReq);
                if (valid[idx]) begin
                    g[idx] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/sda_kernel_param_arbiter_if.sv
// Requester-side and parameter-RAM-side channels of the parameter read-port arbiter.
// Latency: n/a (wiring only).
// Backpressure: valid/stop on every channel; a transfer is valid=1 with stop=0.
interface sda_kernel_param_arbiter_if #(
    parameter int NumReq = 4
);
    logic [NumReq-1:0]    reqAddrValid;
    logic [32*NumReq-1:0] reqAddr;
    logic [NumReq-1:0]    reqAddrStop;
    logic [NumReq-1:0]    reqDataValid;
    logic [32*NumReq-1:0] reqData;
    logic [NumReq-1:0]    reqDataStop;
    logic                 paramAddrValid;
    logic [31:0]          paramAddr;
    logic                 paramAddrStop;
    logic                 paramDataValid;
    logic [31:0]          paramData;
    logic                 paramDataStop;

    modport slave (
        input  reqAddrValid, reqAddr, reqDataStop,
        input  paramAddrStop, paramDataValid, paramData,
        output reqAddrStop, reqDataValid, reqData,
        output paramAddrValid, paramAddr, paramDataStop
    );

    modport master (
        output reqAddrValid, reqAddr, reqDataStop,
        output paramAddrStop, paramDataValid, paramData,
        input  reqAddrStop, reqDataValid, reqData,
        input  paramAddrValid, paramAddr, paramDataStop
    );
endinterface

// File: rtl/sda_kernel_param_arbiter_tag_fifo.sv
// In-order FIFO of requester tags for reads outstanding at the parameter RAM.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push ignored when full unless popping; pop ignored when empty.
module sda_param_tag_fifo
    import sda_param_arb_pkg::*;
#(
    parameter int Depth = 4,
    parameter int Width = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          push,
    input  logic [Width-1:0]              pushData,
    input  logic                          pop,
    output logic [Width-1:0]              popData,
    output logic                          full,
    output logic                          empty,
    output logic [countWidthOf(Depth)-1:0] count
);
    localparam int PtrWidth   = $clog2(Depth);
    localparam int CountWidth = countWidthOf(Depth);

    logic [Width-1:0]      mem [Depth];
    logic [PtrWidth-1:0]   wrPtr;
    logic [PtrWidth-1:0]   rdPtr;
    logic [CountWidth-1:0] count_q;
    logic                  doPush;
    logic                  doPop;

    assign full    = (count_q == CountWidth'(Depth));
    assign empty   = (count_q == '0);
    assign doPush  = push & (~full | pop);
    assign doPop   = pop & ~empty;
    assign popData = mem[rdPtr];
    assign count   = count_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PtrWidth'(1);
            if (doPop)  rdPtr <= rdPtr + PtrWidth'(1);
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + CountWidth'(1);
                2'b01:   count_q <= count_q - CountWidth'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is only consumed when the count says it is live.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/sda_kernel_param_arbiter.sv
// Round-robin share of the parameter RAM read port; returned words go to the issuing requester.
// Latency: granted address on paramAddr next cycle; data return is combinational on the tag FIFO head.
// Backpressure: grants stop when the address register is stalled or TagDepth reads are in flight. Optional SDA_PARAM_ARB_ERRCHK_EN adds sticky protoErr.
module sda_kernel_param_arbiter
    import sda_param_arb_pkg::*;
#(
    parameter int NumReq   = 4,
    parameter int TagDepth = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    sda_kernel_param_arbiter_if.slave   bus,
    output logic                        protoErr
);
    localparam int TagWidth   = tagWidthOf(NumReq);
    localparam int CountWidth = countWidthOf(TagDepth);
    localparam int OccWidth   = CountWidth + 1;

    logic                  outValid_q;
    logic [31:0]           outAddr_q;
    logic [TagWidth-1:0]   outTag_q;
    logic [TagWidth-1:0]   rrPtr;

    logic [CountWidth-1:0] fifoCount;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic [TagWidth-1:0]   headTag;

    logic                  canLoad;
    logic                  addrXfer;
    logic                  dataXfer;
    logic                  room;
    logic [OccWidth-1:0]   occupancy;
    logic [MaxReq-1:0]     rrVec;
    logic                  grantAny;
    logic [NumReq-1:0]     grant;
    logic [TagWidth-1:0]   grantIdx;
    logic [TagWidth-1:0]   nextPtr;
    logic [31:0]           grantAddr;
    logic                  headStop;

    assign canLoad  = ~outValid_q | ~bus.paramAddrStop;
    assign addrXfer = outValid_q & ~bus.paramAddrStop;

    // The entry still sitting in the output register counts as outstanding.
    assign occupancy = {1'b0, fifoCount} + {{CountWidth{1'b0}}, outValid_q};
    assign room      = (occupancy < OccWidth'(TagDepth)) & ~fifoFull;

    assign rrVec    = rrGrant(MaxReq'(bus.reqAddrValid), 4'(rrPtr), NumReq);
    assign grantAny = rstn & canLoad & room & (|rrVec);
    assign grant    = grantAny ? rrVec[NumReq-1:0] : '0;

    always_comb begin
        grantIdx  = '0;
        grantAddr = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (grant[i]) begin
                grantIdx  = TagWidth'(i);
                grantAddr = bus.reqAddr[32*i +: 32];
            end
        end
    end

    assign nextPtr = (grantIdx == TagWidth'(NumReq - 1)) ? '0 : grantIdx + TagWidth'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outValid_q <= 1'b0;
            outAddr_q  <= '0;
            outTag_q   <= '0;
            rrPtr      <= '0;
        end else if (canLoad) begin
            outValid_q <= grantAny;
            if (grantAny) begin
                outAddr_q <= grantAddr;
                outTag_q  <= grantIdx;
                rrPtr     <= nextPtr;
            end
        end
    end

    assign bus.reqAddrStop    = ~grant;
    assign bus.paramAddrValid = outValid_q;
    assign bus.paramAddr      = outAddr_q;

    sda_param_tag_fifo #(
        .Depth (TagDepth),
        .Width (TagWidth)
    ) tagFifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (addrXfer),
        .pushData (outTag_q),
        .pop      (dataXfer),
        .popData  (headTag),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    always_comb begin
        bus.reqDataValid = '0;
        headStop         = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if (headTag == TagWidth'(i)) begin
                bus.reqDataValid[i] = bus.paramDataValid & ~fifoEmpty;
                headStop            = bus.reqDataStop[i];
            end
        end
    end

    // Data arriving with nothing outstanding is held off rather than routed anywhere.
    assign bus.paramDataStop = fifoEmpty | headStop;
    assign dataXfer          = bus.paramDataValid & ~bus.paramDataStop;
    assign bus.reqData       = {NumReq{bus.paramData}};

`ifdef SDA_PARAM_ARB_ERRCHK_EN
    logic protoErr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            protoErr_q <= 1'b0;
        end else if (bus.paramDataValid & fifoEmpty) begin
            protoErr_q <= 1'b1;
        end
    end

    assign protoErr = protoErr_q;
`else
    assign protoErr = 1'b0;
`endif

endmodule

// File: doc/sda_kernel_param_arbiter.md
# sda_kernel_param_arbiter

Shares the single SELF parameter read port of the kernel control parameter RAM between several kernel-side requesters. It round-robin arbitrates address requests onto the one downstream address channel and records the winner's index in an in-order tag FIFO. It then routes each returned parameter data word back to the requester that issued it. It sits between the kernel datapath's parameter fetch units and the parameter RAM block.

## Interface
- NumReq, 4, number of requesters (2..16)
- TagDepth, 4, maximum outstanding downstream reads (power of two, 2..16)
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- reqAddrValid  in  NumReq  per-requester address valid
- reqAddr  in  32*NumReq  per-requester byte address; requester i occupies bits [32i+31:32i]
- reqAddrStop  out  NumReq  per-requester address backpressure
- reqDataValid  out  NumReq  per-requester data valid
- reqData  out  32*NumReq  per-requester data (the same word replicated in every slice)
- reqDataStop  in  NumReq  per-requester data backpressure
- paramAddrValid  out  1  downstream address valid
- paramAddr  out  32  downstream byte address
- paramAddrStop  in  1  downstream address backpressure
- paramDataValid  in  1  downstream data valid
- paramData  in  32  downstream data
- paramDataStop  out  1  downstream data backpressure
- protoErr  out  1  sticky protocol error flag

## Operation
- SELF handshake on every channel: a transfer occurs when valid=1 and stop=0. A valid source holds valid and data stable until the transfer.
- Output address register (outValid_q, outAddr_q, outTag_q) drives paramAddrValid/paramAddr. It can load when ~outValid_q | ~paramAddrStop.
- Grant rule: evaluated combinationally each cycle.
  - Conditions: output register can load, and occupancy < TagDepth. Occupancy is the FIFO count plus outValid_q when that entry has not yet transferred.
  - Winner: the first i with reqAddrValid[i]=1, scanning from rrPtr upward modulo NumReq.
- reqAddrStop[i] = ~grant[i]. Every non-granted requester sees stop=1.
- On a grant to i: outAddr_q <= reqAddr[i], outTag_q <= i, outValid_q <= 1, rrPtr <= (i+1) mod NumReq.
- If the register can load but there is no grant, outValid_q <= 0.
- Tag FIFO push on each downstream address transfer (paramAddrValid & ~paramAddrStop), carrying outTag_q.
- Tag FIFO pop on each downstream data transfer (paramDataValid & ~paramDataStop). Push and pop may occur in the same cycle; count is unchanged.
- Data return, combinational on the FIFO head h:
  - reqDataValid[i] = paramDataValid & ~empty & (h==i)
  - reqData slices = paramData
  - paramDataStop = empty | reqDataStop[h]
- protoErr is set, and stays set until reset, when paramDataValid=1 while the tag FIFO is empty. In that case the data is stalled (stop=1) and no requester sees valid.

## Timing
- Reset (rstn low, asynchronous) values:
  - paramAddrValid=0, paramAddr=0, rrPtr=0, FIFO empty, protoErr=0
  - Combinational outputs during reset: reqAddrStop all 1, reqDataValid all 0, paramDataStop=1
- Address latency: a granted request appears on paramAddrValid in the next cycle.
- Throughput: one grant per cycle when the downstream does not stall.
- Full: when occupancy = TagDepth, all reqAddrStop=1. A pop in cycle n allows a grant in cycle n+1 (the count is registered).
- Mid-operation reset: in-flight tags are discarded. Data returned after reset with an empty FIFO raises protoErr.
- rrPtr wraps NumReq-1 -> 0. With one active requester, grants go back-to-back.

## Configuration
- SDA_PARAM_ARB_ERRCHK_EN:
  - Defined: protoErr detection as described above.
  - Undefined: protoErr is tied to 0 and the register is removed. paramDataStop is still asserted when the FIFO is empty.

## Structure
- Package sda_param_arb_pkg holds:
  - TagWidth = clog2(NumReq), minimum 1
  - CountWidth = clog2(TagDepth)+1
  - the rotate-priority grant function
- One sub-module: sda_param_tag_fifo. It is a synchronous FIFO of TagDepth x TagWidth with push/pop/full/empty/count and async active-low reset.

## Test plan
- Single requester: req 2 issues addr 0x40, downstream returns 0xDEADBEEF after 2 cycles. Expect paramAddr=0x40 one cycle after the grant, reqDataValid=4'b0100, and reqData slice 2 = 0xDEADBEEF.
- Round robin: all 4 requesters hold valid continuously with no stalls. Expect grant order 0,1,2,3,0,… and rrPtr wrapping.
- Full: TagDepth=4, downstream withholds data. Expect exactly 4 address transfers, then all reqAddrStop=1. One data return re-enables a grant in the following cycle.
- Backpressure: paramAddrStop=1 for 3 cycles. paramAddr stays stable and no further grant occurs. Separately, reqDataStop[h]=1 asserts paramDataStop=1 while the data word is held.
- Ordering: requesters 3,0,1 each issue once and data returns A,B,C. Expect A to req 3, B to req 0, C to req 1.
- Error (macro defined): paramDataValid=1 with the FIFO empty. Expect protoErr=1 from the next cycle until rstn low; paramDataStop=1.
